// File: rtl/data_ram_arbiter_pkg.sv
// Shared encodings for the data_ram arbiter: access lengths, lane positions and sequencer states.
package data_ram_arbiter_pkg;

    localparam logic [1:0] mem_len_byte = 2'd0;
    localparam logic [1:0] mem_len_half = 2'd1;
    localparam logic [1:0] mem_len_word = 2'd2;

    localparam int BYTE_W  = 8;
    localparam int HALF_W  = 16;
    localparam int HALF_HI = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RDATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_ram_arbiter_lane_extract.sv
// Combinational load aligner: picks the byte/half lane from a RAM word and sign- or zero-extends it.
// No latency, no flow control; word accesses pass through with the lane bits ignored.
module data_ram_lane_extract
    import data_ram_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_len,
    input  logic [1:0]        i_lane,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;
    logic              sign_bit;

    always_comb begin
        case (i_lane)
            2'd0:    byte_sel = i_word[7:0];
            2'd1:    byte_sel = i_word[15:8];
            2'd2:    byte_sel = i_word[23:16];
            default: byte_sel = i_word[31:24];
        endcase
        half_sel = i_lane[1] ? i_word[HALF_HI +: HALF_W] : i_word[HALF_W-1:0];

        sign_bit = 1'b0;
        case (i_len)
            mem_len_byte: begin
                sign_bit = ~i_unsigned & byte_sel[BYTE_W-1];
                o_data   = {{(DATA_W-BYTE_W){sign_bit}}, byte_sel};
            end
            mem_len_half: begin
                sign_bit = ~i_unsigned & half_sel[HALF_W-1];
                o_data   = {{(DATA_W-HALF_W){sign_bit}}, half_sel};
            end
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares data_ram between LSU (port 0) and loader (port 1): gnt at +1, store ack +2, load ack/rdata +3;
// losers stay pending indefinitely. DATA_RAM_ARB_RR_EN selects round-robin ties, else port 0 wins.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [1:0]        i_m0_len,
    input  logic              i_m0_unsigned,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_gnt,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [1:0]        i_m1_len,
    input  logic              i_m1_unsigned,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_ram_we,
    output logic [1:0]        o_ram_len,
    output logic [ADDR_W-1:0] o_ram_w_addr,
    output logic [DATA_W-1:0] o_ram_w_data,
    output logic [ADDR_W-1:0] o_ram_r_addr,
    input  logic [DATA_W-1:0] i_ram_r_data,
    output logic              o_busy
);

    arb_state_e        state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [1:0]        len_q, len_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] ext_data;
    logic              any_req;
    logic              pick;
    logic              issue;

    assign any_req = i_m0_req | i_m1_req;

`ifdef DATA_RAM_ARB_RR_EN
    // last_q holds the previous winner; a tie goes to the other port
    logic last_q, last_d;

    assign pick = (i_m0_req & i_m1_req) ? ~last_q : ~i_m0_req;

    always_comb begin
        last_d = last_q;
        if (state_q == ARB_IDLE && any_req)
            last_d = pick;
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) last_q <= 1'b1;
        else         last_q <= last_d;
    end
`else
    assign pick = ~i_m0_req;
`endif

    data_ram_lane_extract #(.DATA_W(DATA_W)) u_extract (
        .i_word     (i_ram_r_data),
        .i_len      (len_q),
        .i_lane     (addr_q[1:0]),
        .i_unsigned (uns_q),
        .o_data     (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        len_d    = len_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    port_d  = pick;
                    we_d    = pick ? i_m1_we       : i_m0_we;
                    len_d   = pick ? i_m1_len      : i_m0_len;
                    uns_d   = pick ? i_m1_unsigned : i_m0_unsigned;
                    addr_d  = pick ? i_m1_addr     : i_m0_addr;
                    wdata_d = pick ? i_m1_wdata    : i_m0_wdata;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (we_q) begin
                    ack_d[port_q] = 1'b1;
                    state_d       = ARB_IDLE;
                end else begin
                    state_d = ARB_RDATA;
                end
            end
            ARB_RDATA: begin
                if (port_q) rdata1_d = ext_data;
                else        rdata0_d = ext_data;
                ack_d[port_q] = 1'b1;
                state_d       = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ARB_IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            len_q    <= mem_len_word;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            len_q    <= len_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // RAM sees the latched request only during ISSUE; idle values match reset
    assign issue        = (state_q == ARB_ISSUE);
    assign o_ram_we     = issue & we_q;
    assign o_ram_len    = issue ? len_q : mem_len_word;
    assign o_ram_w_addr = issue ? addr_q : '0;
    assign o_ram_r_addr = issue ? addr_q : '0;
    assign o_ram_w_data = issue ? wdata_q : '0;

    assign o_m0_gnt   = issue & ~port_q;
    assign o_m1_gnt   = issue & port_q;
    assign o_m0_ack   = ack_q[0];
    assign o_m1_ack   = ack_q[1];
    assign o_m0_rdata = rdata0_q;
    assign o_m1_rdata = rdata1_q;
    assign o_busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural byte-lane RAM behind it.
module tb_data_ram_arbiter;
    import data_ram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_req   [2];
    logic        m_we    [2];
    logic        m_uns   [2];
    logic [1:0]  m_len   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        gnt     [2];
    logic        ack     [2];
    logic [31:0] rdata   [2];
    logic        ram_we;
    logic [1:0]  ram_len;
    logic [31:0] ram_w_addr, ram_w_data, ram_r_addr, ram_r_data;
    logic        busy;
    logic [31:0] mem [256];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .i_Clk        (clk),
        .i_reset      (rst),
        .i_m0_req     (m_req[0]),
        .i_m0_we      (m_we[0]),
        .i_m0_len     (m_len[0]),
        .i_m0_unsigned(m_uns[0]),
        .i_m0_addr    (m_addr[0]),
        .i_m0_wdata   (m_wdata[0]),
        .o_m0_gnt     (gnt[0]),
        .o_m0_ack     (ack[0]),
        .o_m0_rdata   (rdata[0]),
        .i_m1_req     (m_req[1]),
        .i_m1_we      (m_we[1]),
        .i_m1_len     (m_len[1]),
        .i_m1_unsigned(m_uns[1]),
        .i_m1_addr    (m_addr[1]),
        .i_m1_wdata   (m_wdata[1]),
        .o_m1_gnt     (gnt[1]),
        .o_m1_ack     (ack[1]),
        .o_m1_rdata   (rdata[1]),
        .o_ram_we     (ram_we),
        .o_ram_len    (ram_len),
        .o_ram_w_addr (ram_w_addr),
        .o_ram_w_data (ram_w_data),
        .o_ram_r_addr (ram_r_addr),
        .i_ram_r_data (ram_r_data),
        .o_busy       (busy)
    );

    // RAM: word-indexed, registered read, lane placement of right-justified store data
    always @(posedge clk) begin
        ram_r_data <= mem[ram_r_addr[9:2]];
        if (ram_we) begin
            case (ram_len)
                mem_len_byte: mem[ram_w_addr[9:2]][{ram_w_addr[1:0], 3'b000} +: 8] <= ram_w_data[7:0];
                mem_len_half: mem[ram_w_addr[9:2]][{ram_w_addr[1], 4'b0000} +: 16] <= ram_w_data[15:0];
                default:      mem[ram_w_addr[9:2]] <= ram_w_data;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 of the ack cycle.
    task automatic op(input int p, input logic we, input logic [1:0] len, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp,
                      input string tag);
        m_req[p] = 1'b1; m_we[p] = we; m_len[p] = len; m_uns[p] = uns;
        m_addr[p] = addr; m_wdata[p] = wd;
        @(posedge clk); #1;
        chk({tag, ".gnt"}, {31'd0, gnt[p]}, 32'd1);
        chk({tag, ".other_gnt"}, {31'd0, gnt[1-p]}, 32'd0);
        chk({tag, ".ram_we"}, {31'd0, ram_we}, {31'd0, we});
        chk({tag, ".ram_addr"}, we ? ram_w_addr : ram_r_addr, addr);
        m_req[p] = 1'b0;
        @(posedge clk); #1;
        if (we) begin
            chk({tag, ".ack"}, {31'd0, ack[p]}, 32'd1);
            chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        end else begin
            chk({tag, ".early_ack"}, {31'd0, ack[p]}, 32'd0);
            @(posedge clk); #1;
            chk({tag, ".ack"}, {31'd0, ack[p]}, 32'd1);
            chk({tag, ".rdata"}, rdata[p], exp);
        end
    endtask

    initial begin
        int order[$];
        int rem[2];
        int exp_order[8];

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 1'b0; m_we[i] = 1'b0; m_uns[i] = 1'b0;
            m_len[i] = mem_len_word; m_addr[i] = '0; m_wdata[i] = '0;
        end
        @(posedge clk); #1;
        chk("rst.gnt0", {31'd0, gnt[0]}, 32'd0);
        chk("rst.gnt1", {31'd0, gnt[1]}, 32'd0);
        chk("rst.ack0", {31'd0, ack[0]}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst.ram_len", {30'd0, ram_len}, {30'd0, mem_len_word});
        chk("rst.rdata0", rdata[0], 32'd0);
        chk("rst.w_addr", ram_w_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op(0, 1'b1, mem_len_word, 1'b0, 32'h4010, 32'hDEADBEEF, 32'h0, "st_w");
        op(0, 1'b0, mem_len_word, 1'b0, 32'h4010, 32'h0, 32'hDEADBEEF, "ld_w");

        op(1, 1'b1, mem_len_word, 1'b0, 32'h4020, 32'h80FF7F01, 32'h0, "st_w2");
        op(1, 1'b0, mem_len_byte, 1'b0, 32'h4021, 32'h0, 32'h0000007F, "ld_b1s");
        op(1, 1'b0, mem_len_byte, 1'b0, 32'h4023, 32'h0, 32'hFFFFFF80, "ld_b3s");
        op(0, 1'b0, mem_len_half, 1'b1, 32'h4022, 32'h0, 32'h000080FF, "ld_h2u");
        chk("hold.rdata1", rdata[1], 32'hFFFFFF80);
        op(0, 1'b0, mem_len_half, 1'b0, 32'h4022, 32'h0, 32'hFFFF80FF, "ld_h2s");
        op(0, 1'b0, mem_len_half, 1'b0, 32'h4020, 32'h0, 32'h00007F01, "ld_h0s");
        op(0, 1'b0, mem_len_byte, 1'b1, 32'h4023, 32'h0, 32'h00000080, "ld_b3u");
        op(0, 1'b0, mem_len_word, 1'b0, 32'h4022, 32'h0, 32'h80FF7F01, "ld_w_mis");

        op(1, 1'b1, mem_len_word, 1'b0, 32'h4004, 32'h11223344, 32'h0, "st_w3");
        op(1, 1'b1, mem_len_byte, 1'b0, 32'h4005, 32'h000000AB, 32'h0, "st_b");
        op(1, 1'b0, mem_len_word, 1'b0, 32'h4004, 32'h0, 32'h1122AB44, "ld_merge");

        // Reset in the ISSUE cycle of a store
        op(0, 1'b1, mem_len_word, 1'b0, 32'h4030, 32'h55667788, 32'h0, "st_pre");
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_len[0] = mem_len_word;
        m_addr[0] = 32'h4030; m_wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("abort.issue_we", {31'd0, ram_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort.ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort.gnt0", {31'd0, gnt[0]}, 32'd0);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.rdata0", rdata[0], 32'd0);
        chk("abort.rdata1", rdata[1], 32'd0);
        chk("abort.w_data", ram_w_data, 32'd0);
        m_req[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort.ack0", {31'd0, ack[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        op(1, 1'b0, mem_len_word, 1'b0, 32'h4030, 32'h0, 32'h55667788, "abort.word");

        // Contention: both ports keep a store pending until each has had 4 grants
`ifdef DATA_RAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        rem[0] = 4; rem[1] = 4;
        for (int q = 0; q < 2; q++) begin
            m_req[q] = 1'b1; m_we[q] = 1'b1; m_len[q] = mem_len_word;
            m_addr[q] = 32'h4100 + 32'(q) * 32'h40; m_wdata[q] = 32'(q);
        end
        for (int c = 0; c < 100 && (rem[0] > 0 || rem[1] > 0); c++) begin
            @(posedge clk); #1;
            for (int q = 0; q < 2; q++) begin
                if (gnt[q]) begin
                    order.push_back(q);
                    rem[q]--;
                    if (rem[q] == 0) m_req[q] = 1'b0;
                    else m_addr[q] = m_addr[q] + 32'd4;
                end
            end
        end
        chk("cont.count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("cont.grant%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd99,
                32'(exp_order[i]));
        @(posedge clk); #1;
        chk("cont.last_ack", {31'd0, ack[1]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter and sequencer in front of `data_ram`. It shares the single RAM between the core load/store unit (port 0) and the program/debug loader (port 1). Each granted request is latched and driven onto the RAM for exactly one cycle. For reads, the block aligns the returned word to the requested byte or half lane and sign- or zero-extends it before returning it to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 32: address width; matches `RAMAddrBus`.
- `DATA_W`, 32: data width; matches `RAMDataBus`.

Ports:
- `i_Clk`  in  1  clock
- `i_reset`  in  1  reset, asynchronous, active-high
- `i_mN_req`  in  1  request, N = 0,1; held with fields stable until `o_mN_gnt`
- `i_mN_we`  in  1  1 = store, 0 = load
- `i_mN_len`  in  2  `mem_len_word` / `mem_len_half` / `mem_len_byte`
- `i_mN_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `i_mN_addr`  in  ADDR_W  byte address
- `i_mN_wdata`  in  DATA_W  store data, right-justified
- `o_mN_gnt`  out  1  one-cycle pulse; request accepted
- `o_mN_ack`  out  1  one-cycle pulse; store done / load data valid
- `o_mN_rdata`  out  DATA_W  extended load data, valid with ack
- `o_ram_we`, `o_ram_len`, `o_ram_w_addr`, `o_ram_w_data`, `o_ram_r_addr`  out  to RAM
- `i_ram_r_data`  in  DATA_W  RAM registered read data
- `o_busy`  out  1  state != IDLE

## Operation
States:
- **IDLE**: if any request is pending, pick a winner, latch its fields, and go to ISSUE.
- **ISSUE**: drive the latched request to the RAM.
  - Store: go to IDLE.
  - Load: go to RDATA.
- **RDATA**: capture `i_ram_r_data`, extract the lane, register the result, and go to IDLE.

Datapath rules:
- RAM drive is combinational from state ISSUE plus the latch. `o_ram_we` = ISSUE & latched we.
- Address passes unmodified. RAM handles the 0x4000–0x7FFF remap and word indexing.
- Extraction:
  - word: full word; `addr[1:0]` is ignored.
  - half: `addr[1]` selects `[15:0]` or `[31:16]`.
  - byte: `addr[1:0]` selects the byte.
  - Extension is per `i_mN_unsigned`.
- No misalignment check. Word/half misaligned accesses behave as the RAM's truncated index dictates.
- Winner identity is latched. `gnt`, `ack` and `rdata` go only to that port. The other port's `rdata` holds its last value.
- A request that is not granted stays pending indefinitely. The block never drops a request.
- Simultaneous requests are resolved per Configuration.

## Timing
- Request seen in IDLE in cycle N:
  - `gnt` high in N+1 (state ISSUE, RAM driven).
  - Store: written at the end of N+1; `ack` in N+2; IDLE in N+2.
  - Load: RAM data in N+2 (RDATA); `ack` and `rdata` in N+3; IDLE in N+3.
- A new arbitration can start in the IDLE cycle in which `ack` fires.
  - Back-to-back throughput: stores 1 per 2 cycles, loads 1 per 3 cycles.
- The requester must deassert `req` (or present the next request) in the cycle after `gnt`. `req` high in IDLE is always a new request.
- Reset values:
  - state IDLE; all `gnt`, `ack`, `o_busy`, `o_ram_we` = 0.
  - `rdata`, addresses and wdata = 0.
  - `o_ram_len` = `mem_len_word`.
  - round-robin pointer favours port 0.
- Reset mid-operation aborts immediately. `o_ram_we` drops asynchronously, no ack is issued, and the latched request is lost.

## Configuration
- `DATA_RAM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the port that did not win last is granted.
  - The pointer updates on every grant.
- `DATA_RAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties; no pointer register.

## Structure
- Length codes `mem_len_*` and the lane indices stay in `defines.v`.
- Add the state encodings `ARB_IDLE`, `ARB_ISSUE` and `ARB_RDATA` (2-bit) to `defines.v`.
- One combinational sub-module `data_ram_lane_extract` (word, len, addr[1:0], unsigned -> extended word), reused later by the load path.

## Test plan
- Port 0 stores word 0xDEADBEEF to 0x4010, then port 0 loads word 0x4010 -> `gnt` at N+1, store `ack` at N+2, load `ack` 3 cycles after its request with `rdata` 0xDEADBEEF.
- Word 0x80FF7F01 at 0x4020; load byte at 0x4021 signed -> 0xFFFFFF FF? no: byte = 0x7F -> 0x0000007F. Load byte at 0x4023 signed -> 0xFFFFFF80. Load half at 0x4022 unsigned -> 0x000080FF.
- Both ports request in the same cycle, 4 times, holding each request until its grant:
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: port 0 wins every tie; port 1 is granted only when port 0 is idle.
- Byte store 0xAB at 0x4005 over 0x11223344 -> reload word = 0x1122AB44.
- `i_reset` asserted during ISSUE of a store -> `o_ram_we` low in the same cycle, no ack, word unchanged, all outputs at reset values.
- Port 1 holds `req` while port 0 streams requests (fixed build) -> port 1 stays pending with `gnt` low, then is granted the first cycle port 0 is idle.
